// File: rtl/arc4_crack_sched_if.sv
// Handshake and snoop bundle between the ARC4 key-search scheduler and the
// crack top level (KEY/SW glue, init/ksa/prga instances, pt memory snoop).
// Signal suffixes are written from the scheduler's point of view.
interface arc4_crack_sched_if;
  logic        en_i;
  logic        rdy_o;
  logic [23:0] key_o;
  logic        key_valid_o;
  logic [23:0] cand_key_o;
  logic        init_en_o;
  logic        init_rdy_i;
  logic        ksa_en_o;
  logic        ksa_rdy_i;
  logic        prga_en_o;
  logic        prga_rdy_i;
  logic        pt_wren_i;
  logic [7:0]  pt_addr_i;
  logic [7:0]  pt_wrdata_i;
  logic [31:0] tried_o;

  modport slave (
    input  en_i, init_rdy_i, ksa_rdy_i, prga_rdy_i,
           pt_wren_i, pt_addr_i, pt_wrdata_i,
    output rdy_o, key_o, key_valid_o, cand_key_o,
           init_en_o, ksa_en_o, prga_en_o, tried_o
  );

  modport master (
    output en_i, init_rdy_i, ksa_rdy_i, prga_rdy_i,
           pt_wren_i, pt_addr_i, pt_wrdata_i,
    input  rdy_o, key_o, key_valid_o, cand_key_o,
           init_en_o, ksa_en_o, prga_en_o, tried_o
  );
endinterface

// File: rtl/arc4_crack_sched.sv
// Brute-force ARC4 key-search scheduler. Steps a 24-bit candidate key from
// KEY_START to KEY_END, runs init -> ksa -> prga for each candidate, snoops
// the plaintext writes and stops on the first all-printable decryption.
// Optional macro ARC4_CRACK_TRIED_CNT_EN enables the saturating count of
// evaluated candidates on tried_o; without it tried_o is tied to zero.
module arc4_crack_sched #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_END   = 24'hFFFFFF
) (
  input logic               clk,
  input logic               rst_n,
  arc4_crack_sched_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, S_INIT, W_INIT, S_KSA, W_KSA, S_PRGA, W_PRGA, CHECK, DONE
  } state_t;

  state_t      state_q;
  logic        rdy_q;
  logic        key_valid_q;
  logic [23:0] key_q;
  logic [23:0] cand_key_q;
  logic        init_en_q;
  logic        ksa_en_q;
  logic        prga_en_q;
  logic        bad_q;
  logic        busy_seen_q;
  logic        pt_bad_byte;

  // A plaintext byte is rejected if it lands past the length byte and is not printable ASCII
  assign pt_bad_byte = bus.pt_wren_i && (bus.pt_addr_i != 8'h00) &&
                       ((bus.pt_wrdata_i < 8'h20) || (bus.pt_wrdata_i > 8'h7E));

`ifdef ARC4_CRACK_TRIED_CNT_EN
  logic [31:0] tried_q;
  logic [31:0] tried_d;

  // Candidate counter sticks at all-ones rather than wrapping
  assign tried_d     = (tried_q == 32'hFFFF_FFFF) ? tried_q : tried_q + 32'd1;
  assign bus.tried_o = tried_q;
`else
  assign bus.tried_o = 32'h0;
`endif

  assign bus.rdy_o       = rdy_q;
  assign bus.key_o       = key_q;
  assign bus.key_valid_o = key_valid_q;
  assign bus.cand_key_o  = cand_key_q;
  assign bus.init_en_o   = init_en_q;
  assign bus.ksa_en_o    = ksa_en_q;
  assign bus.prga_en_o   = prga_en_q;

  // Search sequencer: start pulses are single-cycle, each W_x waits for the sub-block to go busy then idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      key_q       <= 24'h0;
      key_valid_q <= 1'b0;
      cand_key_q  <= KEY_START;
      init_en_q   <= 1'b0;
      ksa_en_q    <= 1'b0;
      prga_en_q   <= 1'b0;
      bad_q       <= 1'b0;
      busy_seen_q <= 1'b0;
`ifdef ARC4_CRACK_TRIED_CNT_EN
      tried_q     <= 32'h0;
`endif
    end else begin
      init_en_q <= 1'b0;
      ksa_en_q  <= 1'b0;
      prga_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (bus.en_i) begin
            key_valid_q <= 1'b0;
            key_q       <= 24'h0;
            bad_q       <= 1'b0;
            cand_key_q  <= KEY_START;
            rdy_q       <= 1'b0;
`ifdef ARC4_CRACK_TRIED_CNT_EN
            tried_q     <= 32'h0;
`endif
            state_q     <= S_INIT;
          end
        end
        S_INIT: begin
          if (bus.init_rdy_i) begin
            init_en_q   <= 1'b1;
            busy_seen_q <= 1'b0;
            state_q     <= W_INIT;
          end
        end
        W_INIT: begin
          if (busy_seen_q && bus.init_rdy_i) begin
            state_q <= S_KSA;
          end else if (!bus.init_rdy_i) begin
            busy_seen_q <= 1'b1;
          end
        end
        S_KSA: begin
          if (bus.ksa_rdy_i) begin
            ksa_en_q    <= 1'b1;
            busy_seen_q <= 1'b0;
            state_q     <= W_KSA;
          end
        end
        W_KSA: begin
          if (busy_seen_q && bus.ksa_rdy_i) begin
            bad_q   <= 1'b0;
            state_q <= S_PRGA;
          end else if (!bus.ksa_rdy_i) begin
            busy_seen_q <= 1'b1;
          end
        end
        S_PRGA: begin
          if (bus.prga_rdy_i) begin
            prga_en_q   <= 1'b1;
            busy_seen_q <= 1'b0;
            state_q     <= W_PRGA;
          end
        end
        W_PRGA: begin
          if (pt_bad_byte) begin
            bad_q <= 1'b1;
          end
          if (busy_seen_q && bus.prga_rdy_i) begin
            state_q <= CHECK;
          end else if (!bus.prga_rdy_i) begin
            busy_seen_q <= 1'b1;
          end
        end
        CHECK: begin
`ifdef ARC4_CRACK_TRIED_CNT_EN
          tried_q <= tried_d;
`endif
          if (!bad_q) begin
            key_q       <= cand_key_q;
            key_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (cand_key_q == KEY_END) begin
            key_q       <= 24'h0;
            key_valid_q <= 1'b0;
            state_q     <= DONE;
          end else begin
            cand_key_q <= cand_key_q + 24'd1;
            state_q    <= S_INIT;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_crack_sched.sv
// Scoreboard bench for arc4_crack_sched. Two scheduler instances with
// different key ranges share behavioural init/ksa/prga responders; the
// prga responder writes a per-run message into the pt snoop. Expected
// search results come from a plain range walk over the message table.
module tb_arc4_crack_sched;

  localparam int NI = 2;
  localparam logic [23:0] KSTART [NI] = '{24'h000010, 24'hFFFFFE};
  localparam logic [23:0] KEND   [NI] = '{24'h0000FF, 24'hFFFFFF};
`ifdef ARC4_CRACK_TRIED_CNT_EN
  localparam bit TRIED_ON = 1'b1;
`else
  localparam bit TRIED_ON = 1'b0;
`endif

  typedef struct {
    int          inst;
    logic        valid;
    logic [23:0] key;
    int          n;
    int          pb0;
    int          pb1;
    int          pb2;
  } exp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  logic        en      [NI];
  logic [2:0]  subRdy  [NI] = '{default: 3'b111};
  logic        ptWren  [NI] = '{default: 1'b0};
  logic [7:0]  ptAddr  [NI] = '{default: 8'h00};
  logic [7:0]  ptData  [NI] = '{default: 8'h00};
  logic [2:0]  stuck   [NI];
  wire  [2:0]  subEn   [NI];
  wire         rdyO    [NI];
  wire         keyValidO [NI];
  wire  [23:0] keyO    [NI];
  wire  [23:0] candO   [NI];
  wire  [31:0] triedO  [NI];

  int   busyCnt [NI][3] = '{default: 0};
  int   pulses  [NI][3] = '{default: 0};
  int   wrIdx   [NI]    = '{default: 0};
  logic prevRdy [NI]    = '{default: 1'b1};
  logic zeroSeen        = 1'b0;

  logic        runHasGood;
  logic [23:0] runGood;
  int          runLen;
  logic [7:0]  goodMsg [8];
  logic [7:0]  badMsg  [8];

  exp_t scoreQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Free-running clock shared by both scheduler instances
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    arc4_crack_sched_if bus ();
    assign bus.en_i        = en[g];
    assign bus.init_rdy_i  = subRdy[g][0];
    assign bus.ksa_rdy_i   = subRdy[g][1];
    assign bus.prga_rdy_i  = subRdy[g][2];
    assign bus.pt_wren_i   = ptWren[g];
    assign bus.pt_addr_i   = ptAddr[g];
    assign bus.pt_wrdata_i = ptData[g];
    assign subEn[g]        = {bus.prga_en_o, bus.ksa_en_o, bus.init_en_o};
    assign rdyO[g]         = bus.rdy_o;
    assign keyValidO[g]    = bus.key_valid_o;
    assign keyO[g]         = bus.key_o;
    assign candO[g]        = bus.cand_key_o;
    assign triedO[g]       = bus.tried_o;

    arc4_crack_sched #(.KEY_START(KSTART[g]), .KEY_END(KEND[g])) dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus)
    );
  end

  // Message byte the prga model produces for a candidate at pt address idx (1-based)
  function automatic logic [7:0] msgByte(input logic [23:0] cand, input int idx);
    if (runHasGood && cand == runGood) return goodMsg[idx-1];
    return badMsg[idx-1];
  endfunction

  function automatic logic allPrintable(input logic [23:0] cand);
    logic [7:0] b;
    for (int i = 1; i <= runLen; i++) begin
      b = msgByte(cand, i);
      if (b < 8'h20 || b > 8'h7E) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference search: walk the key range in order and stop at the first clean message
  task automatic modelSearch(input logic [23:0] ks, input logic [23:0] ke,
                             output logic found, output logic [23:0] k, output int n);
    found = 1'b0;
    k     = 24'h0;
    n     = 0;
    for (int c = int'(ks); c <= int'(ke); c++) begin
      n++;
      if (allPrintable(24'(c))) begin
        found = 1'b1;
        k     = 24'(c);
        break;
      end
    end
  endtask

  function automatic logic [63:0] randPrintable();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'($urandom_range(32, 126));
    return v;
  endfunction

  function automatic logic [7:0] badPick();
    case ($urandom_range(0, 5))
      0: return 8'h1F;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'h80;
      4: return 8'hFF;
      default: return 8'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Behavioural init/ksa/prga: go busy on a start pulse, prga writes length byte then message with random gaps
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      ptWren[g] <= 1'b0;
      ptAddr[g] <= 8'($urandom);
      ptData[g] <= 8'($urandom);
      for (int b = 0; b < 3; b++) begin
        if (subEn[g][b]) begin
          pulses[g][b] <= pulses[g][b] + 1;
          if (!stuck[g][b]) begin
            subRdy[g][b]  <= 1'b0;
            busyCnt[g][b] <= $urandom_range(1, 4);
          end
          if (b == 2) wrIdx[g] <= 0;
        end else if (!subRdy[g][b]) begin
          if (b == 2 && wrIdx[g] <= runLen) begin
            if ($urandom_range(0, 3) != 0) begin
              ptWren[g] <= 1'b1;
              ptAddr[g] <= 8'(wrIdx[g]);
              ptData[g] <= (wrIdx[g] == 0) ? 8'(runLen) : msgByte(candO[g], wrIdx[g]);
              wrIdx[g]  <= wrIdx[g] + 1;
            end
          end else if (busyCnt[g][b] == 0) begin
            subRdy[g][b] <= 1'b1;
          end else begin
            busyCnt[g][b] <= busyCnt[g][b] - 1;
          end
          if (b == 0 && $urandom_range(0, 1) == 1) begin
            ptWren[g] <= 1'b1;
            ptAddr[g] <= 8'($urandom_range(1, 255));
            ptData[g] <= 8'h00;
          end
        end
      end
    end
  end

  // Monitor: a rising rdy marks a finished search, compared against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rstN && candO[1] == 24'h0) zeroSeen <= 1'b1;
    for (int g = 0; g < NI; g++) begin
      if (!rstN) begin
        prevRdy[g] <= 1'b1;
      end else begin
        if (rdyO[g] && !prevRdy[g]) begin
          if (scoreQ.size() == 0) begin
            checkOutput("result_pending", 32'(scoreQ.size()), 32'd1);
          end else begin
            e = scoreQ.pop_front();
            checkOutput("result_inst", 32'(g), 32'(e.inst));
            checkOutput("key_valid", 32'(keyValidO[g]), 32'(e.valid));
            checkOutput("key", 32'(keyO[g]), 32'(e.key));
            checkOutput("tried", triedO[g], TRIED_ON ? 32'(e.n) : 32'd0);
            checkOutput("init_pulses", 32'(pulses[g][0] - e.pb0), 32'(e.n));
            checkOutput("ksa_pulses", 32'(pulses[g][1] - e.pb1), 32'(e.n));
            checkOutput("prga_pulses", 32'(pulses[g][2] - e.pb2), 32'(e.n));
          end
        end
        prevRdy[g] <= rdyO[g];
      end
    end
  end

  task automatic loadRun(input logic hasGood, input logic [23:0] good, input int len,
                         input logic [63:0] gb, input logic [63:0] bb);
    runHasGood = hasGood;
    runGood    = good;
    runLen     = len;
    for (int i = 0; i < 8; i++) begin
      goodMsg[i] = gb[8*i +: 8];
      badMsg[i]  = bb[8*i +: 8];
    end
  endtask

  // Issue one search, queue its modelled outcome and wait (bounded) for the monitor to consume it
  task automatic applyStimulus(input int g, input logic hasGood, input logic [23:0] good, input int len,
                               input logic [63:0] gb, input logic [63:0] bb, input logic holdEn);
    exp_t        e;
    logic        found;
    logic [23:0] k;
    int          n;
    loadRun(hasGood, good, len, gb, bb);
    modelSearch(KSTART[g], KEND[g], found, k, n);
    e.inst = g; e.valid = found; e.key = k; e.n = n;
    e.pb0 = pulses[g][0]; e.pb1 = pulses[g][1]; e.pb2 = pulses[g][2];
    for (int c = 0; c < 100 && !rdyO[g]; c++) @(negedge clk);
    scoreQ.push_back(e);
    en[g] = 1'b1;
    @(negedge clk);
    if (!holdEn) en[g] = 1'b0;
    for (int c = 0; c < 30000 && scoreQ.size() != 0; c++) begin
      @(negedge clk);
      if (rdyO[g]) en[g] = 1'b0;
    end
    en[g] = 1'b0;
    if (scoreQ.size() != 0) begin
      checkOutput("search_timeout", 32'(scoreQ.size()), 32'd0);
      scoreQ.delete();
    end
    @(negedge clk);
  endtask

  task automatic randomRun(input int g, input logic hasGood, input logic [23:0] good);
    logic [63:0] gb, bb;
    int          len, pos;
    len = $urandom_range(1, 6);
    gb  = randPrintable();
    if ($urandom_range(0, 1) == 1) begin
      gb[7:0]             = 8'h20;
      gb[8*(len-1) +: 8]  = 8'h7E;
    end
    bb  = randPrintable();
    pos = $urandom_range(0, len - 1);
    bb[8*pos +: 8] = badPick();
    applyStimulus(g, hasGood, good, len, gb, bb, 1'b0);
  endtask

  initial begin
    int pk0, pk1, pk2;
    logic seen;
    en    = '{default: 1'b0};
    stuck = '{default: 3'b000};
    loadRun(1'b0, 24'h0, 0, 64'h0, 64'h0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    for (int g = 0; g < NI; g++) begin
      checkOutput("reset_rdy", 32'(rdyO[g]), 32'd1);
      checkOutput("reset_key_valid", 32'(keyValidO[g]), 32'd0);
      checkOutput("reset_key", 32'(keyO[g]), 32'd0);
      checkOutput("reset_cand", 32'(candO[g]), 32'(KSTART[g]));
      checkOutput("reset_tried", triedO[g], 32'd0);
      checkOutput("reset_enables", 32'(subEn[g]), 32'd0);
    end

    $display("[TB] directed searches");
    applyStimulus(0, 1'b1, 24'h000012, 2, 64'h6948, 64'h0101, 1'b0);
    applyStimulus(1, 1'b0, 24'h0, 3, 64'h414141, 64'h417F41, 1'b0);
    checkOutput("cand_no_wrap", 32'(zeroSeen), 32'd0);
    applyStimulus(0, 1'b1, 24'h000011, 2, 64'h7E20, 64'h1F20, 1'b0);
    applyStimulus(0, 1'b1, 24'h000013, 1, 64'h7E, 64'h7F, 1'b0);
    applyStimulus(0, 1'b0, 24'h0, 0, 64'h0, 64'h0, 1'b0);
    applyStimulus(0, 1'b1, 24'h0000FF, 1, 64'h41, 64'h80, 1'b0);
    applyStimulus(0, 1'b1, 24'h000014, 3, 64'h434241, 64'h434200, 1'b1);

    $display("[TB] randomized searches");
    for (int r = 0; r < 6; r++) randomRun(0, 1'b1, KSTART[0] + 24'($urandom_range(0, 25)));
    for (int r = 0; r < 3; r++) randomRun(1, 1'($urandom_range(0, 1)), KSTART[1] + 24'($urandom_range(0, 1)));
    checkOutput("cand_no_wrap_rand", 32'(zeroSeen), 32'd0);

    $display("[TB] reset during ksa");
    loadRun(1'b1, 24'h000015, 2, 64'h6948, 64'h0101);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (subEn[0][1]) seen = 1'b1;
    end
    checkOutput("ksa_reached", 32'(seen), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_rdy", 32'(rdyO[0]), 32'd1);
    checkOutput("rst_ksa_en", 32'(subEn[0][1]), 32'd0);
    checkOutput("rst_key_valid", 32'(keyValidO[0]), 32'd0);
    checkOutput("rst_cand", 32'(candO[0]), 32'(KSTART[0]));
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 24'h000015, 2, 64'h6948, 64'h0101, 1'b0);

    $display("[TB] ksa never goes busy");
    stuck[0] = 3'b010;
    loadRun(1'b1, 24'h000010, 1, 64'h41, 64'h01);
    pk0 = pulses[0][0]; pk1 = pulses[0][1]; pk2 = pulses[0][2];
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (pulses[0][1] != pk1) seen = 1'b1;
    end
    checkOutput("stuck_ksa_started", 32'(seen), 32'd1);
    repeat (60) @(negedge clk);
    checkOutput("stuck_init_pulses", 32'(pulses[0][0] - pk0), 32'd1);
    checkOutput("stuck_ksa_pulses", 32'(pulses[0][1] - pk1), 32'd1);
    checkOutput("stuck_prga_pulses", 32'(pulses[0][2] - pk2), 32'd0);
    checkOutput("stuck_rdy", 32'(rdyO[0]), 32'd0);
    rstN = 1'b0;
    stuck[0] = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    applyStimulus(0, 1'b1, 24'h000016, 2, 64'h7E20, 64'h7F7F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
